mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single physical memory port between the instruction-fetch requester (I-side, read-only) and the data requester (D-side, read/write) of the rv32i core.
- Each requester sees a private port with the same read/write/resp handshake as physical memory.
- Data accesses have priority. A bounded-streak rule prevents instruction starvation.

Parameters:
MAX_D_STREAK, 4, max consecutive D grants issued while an I request is pending; the next grant goes to I (must be >=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_read  input  1  I-side read request; held until i_resp
i_address  input  32  I-side address
i_resp  output  1  I-side response, one cycle
i_rdata  output  32  I-side read data, valid with i_resp
d_read  input  1  D-side read request; held until d_resp
d_write  input  1  D-side write request; held until d_resp
d_byte_enable  input  4  D-side write byte mask
d_address  input  32  D-side address
d_wdata  input  32  D-side write data
d_resp  output  1  D-side response, one cycle
d_rdata  output  32  D-side read data, valid with d_resp
mem_read  output  1  physical memory read strobe
mem_write  output  1  physical memory write strobe
mem_byte_enable  output  4  physical byte mask
mem_address  output  32  physical address
mem_wdata  output  32  physical write data
mem_resp  input  1  physical memory response
mem_rdata  input  32  physical read data

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- FSM states: IDLE, I_ACCESS, D_ACCESS.
- Registered request fields: read, write, byte_enable, address, wdata. Streak counter d_streak is $clog2(MAX_D_STREAK+1) bits.
- Reset (asynchronous, any state including mid-transaction):
  - state=IDLE, all request registers=0, d_streak=0.
  - mem_read=mem_write=0, mem_byte_enable=0, mem_address=0, mem_wdata=0, i_resp=d_resp=0.
- IDLE:
  - mem strobes=0; mem_resp ignored; no resp forwarded.
  - D wins if (d_read|d_write) and (!i_read or d_streak<MAX_D_STREAK). Latch D fields and go to D_ACCESS.
  - Otherwise, if i_read: latch i_address, read=1, write=0, byte_enable=4'hF, wdata=0; go to I_ACCESS.
  - Otherwise stay in IDLE.
- Streak update at grant:
  - D grant with i_read=1: d_streak+1, saturating at MAX_D_STREAK.
  - D grant with i_read=0: d_streak=0.
  - I grant: d_streak=0.
- d_read and d_write both high: write wins. Latched read=0, write=1.
- Access states:
  - mem_* driven only from the latched registers, never combinationally from requester inputs.
  - Strobes are asserted from the cycle after the grant until mem_resp is sampled.
  - Grant latency is 1 cycle: request seen in cycle N, mem strobe high in N+1.
- Response forwarding:
  - i_resp = mem_resp & (state==I_ACCESS).
  - d_resp = mem_resp & (state==D_ACCESS).
  - i_rdata and d_rdata are both driven by mem_rdata; only resp qualifies them.
- On the mem_resp cycle: clear the read/write registers and go to IDLE. Strobes are low the next cycle.
- Every transaction is followed by at least one IDLE cycle, so memory always sees strobe deassertion between accesses.
- Requester inputs that change mid-access have no effect; the latched copy is used.
- A requester dropping its request mid-access is a protocol violation. The access completes anyway and resp is still pulsed.
- mem_resp arriving in IDLE (e.g. a stale response after reset) is ignored.
- Both requesters idle: FSM stays in IDLE with outputs 0.

Test Plan:
- Reset mid-D_ACCESS (d_write, address 0x100) before mem_resp -> asynchronously: state=IDLE, mem_write=0, d_resp never asserted; a later mem_resp pulse is ignored.
- i_read only, i_address=0x60, memory resp after 3 cycles with rdata=0xDEADBEEF -> mem_read rises 1 cycle after request, mem_address=0x60, mem_byte_enable=4'hF; i_resp one cycle with i_rdata=0xDEADBEEF; mem_read low next cycle; d_resp stays 0.
- Simultaneous i_read (0x40) and d_write (0x80, wdata 0x12345678, be 4'b0011) -> D served first: mem_write=1, mem_byte_enable=4'b0011, mem_wdata=0x12345678; I served only after an IDLE bubble; d_resp precedes i_resp.
- d_read held continuously with i_read pending, MAX_D_STREAK=4 -> exactly 4 D grants, then 1 I grant, then D resumes; d_streak reads 0 after the I grant.
- d_read=d_write=1 at address 0x200 -> mem_write=1, mem_read=0; d_resp pulses once.
- Requester changes d_address from 0x10 to 0x20 mid-access -> mem_address stays 0x10 until mem_resp.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between I-fetch (read-only) and D-side (read/write).
// D-side has priority; a bounded D-grant streak guarantees forward progress for a pending I fetch.
module mem_arbiter #(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_read,
   input  logic [31:0] i_address,
   output logic        i_resp,
   output logic [31:0] i_rdata,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [3:0]  d_byte_enable,
   input  logic [31:0] d_address,
   input  logic [31:0] d_wdata,
   output logic        d_resp,
   output logic [31:0] d_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  mem_byte_enable,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   input  logic        mem_resp,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX  = SW'(MAX_D_STREAK);
   localparam logic [SW-1:0] STREAK_ONE  = SW'(1);
   localparam logic [SW-1:0] STREAK_ZERO = SW'(0);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      I_ACCESS = 2'd1,
      D_ACCESS = 2'd2
   } state_t;

   state_t         state_r;
   logic           read_r;
   logic           write_r;
   logic [3:0]     byte_enable_r;
   logic [31:0]    address_r;
   logic [31:0]    wdata_r;
   logic [SW-1:0]  d_streak_r;

   logic           d_req_s;
   logic           d_win_s;

   // D wins unless an I fetch is waiting and the D streak has hit its limit
   always_comb begin
      d_req_s = d_read | d_write;
      if (i_read) begin
         d_win_s = d_req_s && (d_streak_r < STREAK_MAX);
      end else begin
         d_win_s = d_req_s;
      end
   end

   // Arbitration FSM: grants from IDLE, holds the latched request until mem_resp
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         read_r        <= 1'b0;
         write_r       <= 1'b0;
         byte_enable_r <= 4'h0;
         address_r     <= 32'h0;
         wdata_r       <= 32'h0;
         d_streak_r    <= STREAK_ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (d_win_s) begin
                  state_r       <= D_ACCESS;
                  // a simultaneous read+write request is treated as a write
                  read_r        <= d_read & ~d_write;
                  write_r       <= d_write;
                  byte_enable_r <= d_byte_enable;
                  address_r     <= d_address;
                  wdata_r       <= d_wdata;
                  if (!i_read) begin
                     d_streak_r <= STREAK_ZERO;
                  end else if (d_streak_r < STREAK_MAX) begin
                     d_streak_r <= d_streak_r + STREAK_ONE;
                  end else begin
                     d_streak_r <= STREAK_MAX;
                  end
               end else if (i_read) begin
                  state_r       <= I_ACCESS;
                  read_r        <= 1'b1;
                  write_r       <= 1'b0;
                  byte_enable_r <= 4'hF;
                  address_r     <= i_address;
                  wdata_r       <= 32'h0;
                  d_streak_r    <= STREAK_ZERO;
               end else begin
                  state_r <= IDLE;
               end
            end
            I_ACCESS, D_ACCESS: begin
               if (mem_resp) begin
                  state_r <= IDLE;
                  read_r  <= 1'b0;
                  write_r <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               state_r <= IDLE;
               read_r  <= 1'b0;
               write_r <= 1'b0;
            end
         endcase
      end
   end

   // Memory side comes only from latched registers; responses are qualified by the owner
   always_comb begin
      mem_read        = read_r;
      mem_write       = write_r;
      mem_byte_enable = byte_enable_r;
      mem_address     = address_r;
      mem_wdata       = wdata_r;
      i_resp          = mem_resp & (state_r == I_ACCESS);
      d_resp          = mem_resp & (state_r == D_ACCESS);
      i_rdata         = mem_rdata;
      d_rdata         = mem_rdata;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model with per-cycle
// comparison, a latency-programmable memory responder, and directed scenarios.
module tb_mem_arbiter;

   localparam int MAX_D = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_read;
   logic [31:0] i_address;
   logic        i_resp;
   logic [31:0] i_rdata;
   logic        d_read;
   logic        d_write;
   logic [3:0]  d_byte_enable;
   logic [31:0] d_address;
   logic [31:0] d_wdata;
   logic        d_resp;
   logic [31:0] d_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic        mem_resp = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter #(.MAX_D_STREAK(MAX_D)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
      .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: answers in the (lat+1)-th strobe cycle; force_resp injects a stray pulse
   int          lat = 2;
   bit          force_resp = 1'b0;
   bit          fixed_en = 1'b0;
   logic [31:0] fixed_val = 32'h0;
   int          wait_cnt = 0;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         mem_resp = 1'b0;
         wait_cnt = 0;
      end else if (force_resp) begin
         mem_resp  = 1'b1;
         mem_rdata = 32'hBAD0_BAD0;
      end else if ((mem_read || mem_write) && !mem_resp) begin
         if (wait_cnt >= lat) begin
            mem_resp  = 1'b1;
            mem_rdata = fixed_en ? fixed_val : (mem_address ^ 32'h5A5A_0000);
            wait_cnt  = 0;
         end else begin
            mem_resp = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_resp = 1'b0;
         wait_cnt = 0;
      end
   end

   // Reference model: who owns the port and what transaction it carries
   int          m_owner  = 0;   // 0 none, 1 I, 2 D
   int          m_streak = 0;
   bit          m_rd = 1'b0, m_wr = 1'b0;
   logic [3:0]  m_be = 4'h0;
   logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner  = 0;
         m_streak = 0;
      end else if (m_owner != 0) begin
         if (mem_resp) m_owner = 0;
      end else if ((d_read || d_write) && (!i_read || m_streak < MAX_D)) begin
         m_owner  = 2;
         m_wr     = d_write;
         m_rd     = !d_write;
         m_be     = d_byte_enable;
         m_addr   = d_address;
         m_wdata  = d_wdata;
         m_streak = i_read ? ((m_streak < MAX_D) ? m_streak + 1 : MAX_D) : 0;
      end else if (i_read) begin
         m_owner  = 1;
         m_rd     = 1'b1;
         m_wr     = 1'b0;
         m_be     = 4'hF;
         m_addr   = i_address;
         m_wdata  = 32'h0;
         m_streak = 0;
      end
   end

   // Per-cycle comparison against the model plus DUT-side event logs
   int i_resp_cnt = 0, d_resp_cnt = 0;
   int resp_log[$];
   logic [31:0] grant_log[$];
   bit prev_strobe = 1'b0;

   always @(negedge clk) begin
      chk("mem_read", mem_read, (m_owner != 0) ? m_rd : 1'b0);
      chk("mem_write", mem_write, (m_owner != 0) ? m_wr : 1'b0);
      if (m_owner != 0) begin
         chk("mem_address", mem_address, m_addr);
         chk("mem_byte_enable", mem_byte_enable, m_be);
         chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("i_resp", i_resp, mem_resp && (m_owner == 1));
      chk("d_resp", d_resp, mem_resp && (m_owner == 2));
      chk("i_rdata", i_rdata, mem_rdata);
      chk("d_rdata", d_rdata, mem_rdata);
      if (i_resp) begin i_resp_cnt++; resp_log.push_back(1); end
      if (d_resp) begin d_resp_cnt++; resp_log.push_back(2); end
      if ((mem_read || mem_write) && !prev_strobe) grant_log.push_back(mem_address);
      prev_strobe = mem_read || mem_write;
   end

   task automatic wait_resp(input bit is_d, input int max_cyc, input string name, output int n);
      bit ok = 1'b0;
      n = 0;
      for (int k = 0; k < max_cyc; k++) begin
         @(negedge clk);
         n++;
         if (is_d ? d_resp : i_resp) begin
            ok = 1'b1;
            break;
         end
      end
      chk({name, " resp seen"}, ok, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   logic [31:0] exp_g [6] = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400};
   int n;

   initial begin
      rst = 1'b1;
      i_read = 1'b0; i_address = 32'h0;
      d_read = 1'b0; d_write = 1'b0; d_byte_enable = 4'h0;
      d_address = 32'h0; d_wdata = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst mem_read", mem_read, 1'b0);
      chk("rst mem_write", mem_write, 1'b0);
      chk("rst mem_byte_enable", mem_byte_enable, 4'h0);
      chk("rst mem_address", mem_address, 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      chk("rst i_resp", i_resp, 1'b0);
      chk("rst d_resp", d_resp, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of a D write, then a stale mem_resp
      lat = 100;
      d_write = 1'b1; d_address = 32'h100; d_wdata = 32'hCAFE_0001; d_byte_enable = 4'hF;
      @(negedge clk);
      chk("t1 mem_write granted", mem_write, 1'b1);
      chk("t1 mem_address", mem_address, 32'h100);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t1 async mem_write", mem_write, 1'b0);
      chk("t1 async mem_address", mem_address, 32'h0);
      d_write = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      lat = 2;
      @(negedge clk);
      force_resp = 1'b1;
      @(negedge clk);
      chk("t1 stale mem_resp driven", mem_resp, 1'b1);
      chk("t1 stale d_resp", d_resp, 1'b0);
      force_resp = 1'b0;
      @(negedge clk);
      chk("t1 d_resp count", d_resp_cnt, 0);
      chk("t1 idle strobes", {mem_read, mem_write}, 2'b00);

      // Lone I fetch with a 3-cycle memory
      fixed_en = 1'b1; fixed_val = 32'hDEAD_BEEF;
      i_read = 1'b1; i_address = 32'h60;
      @(negedge clk);
      chk("t2 mem_read latency", mem_read, 1'b1);
      chk("t2 mem_address", mem_address, 32'h60);
      chk("t2 mem_byte_enable", mem_byte_enable, 4'hF);
      wait_resp(1'b0, 10, "t2", n);
      chk("t2 resp cycles", n, 2);
      chk("t2 i_rdata", i_rdata, 32'hDEAD_BEEF);
      i_read = 1'b0;
      @(negedge clk);
      chk("t2 mem_read after resp", mem_read, 1'b0);
      chk("t2 i_resp single", i_resp_cnt, 1);
      chk("t2 d_resp untouched", d_resp_cnt, 0);
      fixed_en = 1'b0;

      // Simultaneous I and D: D first, bubble, then I
      lat = 1;
      resp_log.delete();
      i_read = 1'b1; i_address = 32'h40;
      d_write = 1'b1; d_address = 32'h80; d_wdata = 32'h1234_5678; d_byte_enable = 4'b0011;
      @(negedge clk);
      chk("t3 mem_write", mem_write, 1'b1);
      chk("t3 mem_read", mem_read, 1'b0);
      chk("t3 mem_byte_enable", mem_byte_enable, 4'b0011);
      chk("t3 mem_wdata", mem_wdata, 32'h1234_5678);
      chk("t3 mem_address", mem_address, 32'h80);
      wait_resp(1'b1, 10, "t3 d", n);
      d_write = 1'b0;
      @(negedge clk);
      chk("t3 bubble", {mem_read, mem_write}, 2'b00);
      @(negedge clk);
      chk("t3 i mem_read", mem_read, 1'b1);
      chk("t3 i mem_address", mem_address, 32'h40);
      wait_resp(1'b0, 10, "t3 i", n);
      i_read = 1'b0;
      @(negedge clk);
      chk("t3 resp count", resp_log.size(), 2);
      if (resp_log.size() >= 2) begin
         chk("t3 first resp is D", resp_log[0], 2);
         chk("t3 second resp is I", resp_log[1], 1);
      end

      // Streak limit: continuous D with pending I
      grant_log.delete();
      i_read = 1'b1; i_address = 32'h300;
      d_read = 1'b1; d_address = 32'h400; d_byte_enable = 4'hF;
      wait_resp(1'b0, 60, "t4 i", n);
      chk("t4 d_streak after I grant", dut.d_streak_r, 0);
      i_read = 1'b0;
      wait_resp(1'b1, 10, "t4 d", n);
      d_read = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4 grant count", grant_log.size(), 6);
      for (int g = 0; g < 6; g++) begin
         if (g < grant_log.size()) chk($sformatf("t4 grant %0d", g), grant_log[g], exp_g[g]);
      end

      // Read+write together is a write
      n = d_resp_cnt;
      d_read = 1'b1; d_write = 1'b1; d_address = 32'h200; d_wdata = 32'h0BAD_F00D;
      @(negedge clk);
      chk("t5 mem_write", mem_write, 1'b1);
      chk("t5 mem_read", mem_read, 1'b0);
      chk("t5 mem_address", mem_address, 32'h200);
      wait_resp(1'b1, 10, "t5", n);
      d_read = 1'b0; d_write = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5 d_resp once", d_resp_cnt, 5 + 1 + 1);

      // Address change mid-access is ignored
      lat = 3;
      d_read = 1'b1; d_address = 32'h10;
      @(negedge clk);
      chk("t6 mem_address", mem_address, 32'h10);
      d_address = 32'h20;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("t6 mem_address held", mem_address, 32'h10);
         if (d_resp) break;
      end
      chk("t6 resp reached", d_resp, 1'b1);
      d_read = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6 idle strobes", {mem_read, mem_write}, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
